// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_pkg
// Description : Shared defaults, pipeline-depth helper and per-stage control
//               record for the chunked pipelined adder.
//               The partial-sum vector of each stage is kept beside this
//               record because its width follows the instance parameter W.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

    localparam int c_w_default     = 32;
    localparam int c_chunk_default = 8;

    // Pipeline depth: one stage per CHUNK-bit slice, last slice may be short.
    function automatic int adder_stages(input int w, input int chunk);
        return (w + chunk - 1) / chunk;
    endfunction

    // Control bits that travel with each pair through the pipe.
    typedef struct packed {
        logic cout;   // carry out of this stage's slice
        logic valid;  // stage holds a live pair
        logic sub;    // pair was issued as a subtraction
    } stage_ctl_t;

endpackage
`default_nettype wire

// File: rtl/chunk_add.sv
`default_nettype none
// ============================================================================
// Module      : chunk_add
// Description : Purely combinational N-bit ripple slice adder.
// Ports       : x, y  - N-bit addends
//               cin   - carry in
//               s     - N-bit sum
//               cout  - carry out of bit N-1
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_add
    import adder_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    assign {cout, s} = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipe_adder
// Description : W-bit adder pipelined as ceil(W/CHUNK) ripple slices with a
//               valid/ready handshake on both sides and a single global
//               advance enable (the whole pipe stalls together).
// Ports       : clk, rst_n        - clock, async active-low reset
//               a, b, in_valid    - operand pair, offered this cycle
//               in_ready          - pair is accepted this cycle
//               sum, carry        - result and carry out of bit W-1
//               out_valid         - sum/carry are valid
//               out_ready         - consumer takes sum/carry this cycle
//               sub               - (PIPE_ADDER_SUB_EN only) a-b instead of a+b
// Config      : define PIPE_ADDER_SUB_EN to add subtraction support.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_adder
    import adder_pkg::*;
#(
    parameter int W     = c_w_default,
    parameter int CHUNK = c_chunk_default
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] sum,
    output logic         carry,
    output logic         out_valid,
    input  logic         out_ready
`ifdef PIPE_ADDER_SUB_EN
    ,
    input  logic         sub
`endif
);

    localparam int STAGES = adder_stages(W, CHUNK);

    logic w_en;
    logic w_sub_issue;

`ifdef PIPE_ADDER_SUB_EN
    assign w_sub_issue = sub;
`else
    assign w_sub_issue = 1'b0;
`endif

    // A stalled full output freezes every stage; otherwise everything shifts.
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    // Each stage carries two W-bit vectors:
    //   x : already-summed slices in the low bits, untouched a bits above
    //   y : b (pre-inverted for subtraction); only its upper bits still matter
    // Stage k overwrites slice k of x with the slice sum.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int c_lo = k * CHUNK;
        localparam int c_cw = ((W - c_lo) < CHUNK) ? (W - c_lo) : CHUNK;

        logic [W-1:0]    w_x_in;
        logic [W-1:0]    w_y_in;
        logic            w_cin;
        logic            w_vld_in;
        logic            w_sub_in;
        logic [c_cw-1:0] w_s;
        logic            w_cout;

        logic [W-1:0]    x_d, x_q;
        logic [W-1:0]    y_d, y_q;
        stage_ctl_t      ctl_d, ctl_q;

        if (k == 0) begin : g_head
            assign w_x_in   = a;
            assign w_y_in   = w_sub_issue ? ~b : b;
            assign w_cin    = w_sub_issue;
            assign w_vld_in = in_valid;
            assign w_sub_in = w_sub_issue;
        end else begin : g_body
            assign w_x_in   = g_stage[k-1].x_q;
            assign w_y_in   = g_stage[k-1].y_q;
            assign w_cin    = g_stage[k-1].ctl_q.cout;
            assign w_vld_in = g_stage[k-1].ctl_q.valid;
            assign w_sub_in = g_stage[k-1].ctl_q.sub;
        end

        chunk_add #(
            .N    (c_cw)
        ) u_chunk_add (
            .x    (w_x_in[c_lo +: c_cw]),
            .y    (w_y_in[c_lo +: c_cw]),
            .cin  (w_cin),
            .s    (w_s),
            .cout (w_cout)
        );

        // Data fields only load behind a live pair so the output stage keeps
        // its last result through bubbles.
        always_comb begin
            x_d   = x_q;
            y_d   = y_q;
            ctl_d = ctl_q;
            if (w_en) begin
                ctl_d.valid = w_vld_in;
                if (w_vld_in) begin
                    x_d               = w_x_in;
                    x_d[c_lo +: c_cw] = w_s;
                    y_d               = w_y_in;
                    ctl_d.cout        = w_cout;
                    ctl_d.sub         = w_sub_in;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                x_q   <= '0;
                y_q   <= '0;
                ctl_q <= '0;
            end else begin
                x_q   <= x_d;
                y_q   <= y_d;
                ctl_q <= ctl_d;
            end
        end
    end

    assign sum       = g_stage[STAGES-1].x_q;
    assign carry     = g_stage[STAGES-1].ctl_q.cout;
    assign out_valid = g_stage[STAGES-1].ctl_q.valid;

    // The last stage's copy of b and its sub flag have no consumer.
    logic w_unused_tail;
    assign w_unused_tail = ^{g_stage[STAGES-1].y_q, g_stage[STAGES-1].ctl_q.sub};

endmodule
`default_nettype wire
